// File: rtl/maxpool3d_window_addr_gen.sv
// Window address generator for the 3D max-pooling stage.
// Walks every full K x K x K window of a D x H x W volume stored linearly
// (index = d*H*W + h*W + w). It emits one address per element, with
// first/last-of-window markers, over a valid/ready stream.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, all outputs low
// ST_RUN   | presenting addresses; counters step on each handshake
// ST_DONE  | one-cycle done pulse after the final handshake
module maxpool3d_window_addr_gen #(
    parameter int D      = 4,
    parameter int H      = 4,
    parameter int W      = 4,
    parameter int K      = 2,
    parameter int S      = 2,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              win_first,
    output logic              win_last
);

    localparam int OD = (D - K) / S + 1;
    localparam int OH = (H - K) / S + 1;
    localparam int OW = (W - K) / S + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_od, r_oh, r_ow, r_kd, r_kh, r_kw;
    logic [ADDR_W-1:0] w_od_nxt, w_oh_nxt, w_ow_nxt, w_kd_nxt, w_kh_nxt, w_kw_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_win_first, r_win_last;
    logic              w_first_nxt, w_last_nxt;
    logic              w_hs;
    logic              w_kw_wrap, w_kh_wrap, w_kd_wrap, w_ow_wrap, w_oh_wrap, w_final;

    assign w_hs      = (r_state == ST_RUN) && addr_ready;

    // Carry chain: each wrap term means "this counter and all inner ones are at max".
    assign w_kw_wrap = (r_kw == ADDR_W'(K - 1));
    assign w_kh_wrap = w_kw_wrap && (r_kh == ADDR_W'(K - 1));
    assign w_kd_wrap = w_kh_wrap && (r_kd == ADDR_W'(K - 1));
    assign w_ow_wrap = w_kd_wrap && (r_ow == ADDR_W'(OW - 1));
    assign w_oh_wrap = w_ow_wrap && (r_oh == ADDR_W'(OH - 1));
    assign w_final   = w_oh_wrap && (r_od == ADDR_W'(OD - 1));

    // Next counter values for the element after the current one.
    always_comb begin
        w_kw_nxt = w_kw_wrap ? '0 : r_kw + ADDR_W'(1);
        w_kh_nxt = r_kh;
        w_kd_nxt = r_kd;
        w_ow_nxt = r_ow;
        w_oh_nxt = r_oh;
        w_od_nxt = r_od;
        if (w_kw_wrap) w_kh_nxt = w_kh_wrap ? '0 : r_kh + ADDR_W'(1);
        if (w_kh_wrap) w_kd_nxt = w_kd_wrap ? '0 : r_kd + ADDR_W'(1);
        if (w_kd_wrap) w_ow_nxt = w_ow_wrap ? '0 : r_ow + ADDR_W'(1);
        if (w_ow_wrap) w_oh_nxt = w_oh_wrap ? '0 : r_oh + ADDR_W'(1);
        if (w_oh_wrap) w_od_nxt = w_final   ? '0 : r_od + ADDR_W'(1);
    end

    // Address and markers of the next element, registered on the handshake.
    assign w_addr_nxt  = ADDR_W'((w_od_nxt * ADDR_W'(S) + w_kd_nxt) * ADDR_W'(H * W)
                               + (w_oh_nxt * ADDR_W'(S) + w_kh_nxt) * ADDR_W'(W)
                               +  w_ow_nxt * ADDR_W'(S) + w_kw_nxt);
    assign w_first_nxt = (w_kd_nxt == '0) && (w_kh_nxt == '0) && (w_kw_nxt == '0);
    assign w_last_nxt  = (w_kd_nxt == ADDR_W'(K - 1)) && (w_kh_nxt == ADDR_W'(K - 1))
                       && (w_kw_nxt == ADDR_W'(K - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; start outside IDLE is dropped, not queued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_hs && w_final) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counters and registered address; outputs are cleared outside a pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_od, r_oh, r_ow, r_kd, r_kh, r_kw} <= '0;
            r_addr      <= '0;
            r_win_first <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            {r_od, r_oh, r_ow, r_kd, r_kh, r_kw} <= '0;
            r_addr      <= '0;
            r_win_first <= 1'b1;
            r_win_last  <= (K == 1);
        end else if (w_hs) begin
            r_od <= w_od_nxt;
            r_oh <= w_oh_nxt;
            r_ow <= w_ow_nxt;
            r_kd <= w_kd_nxt;
            r_kh <= w_kh_nxt;
            r_kw <= w_kw_nxt;
            if (w_final) begin
                r_addr      <= '0;
                r_win_first <= 1'b0;
                r_win_last  <= 1'b0;
            end else begin
                r_addr      <= w_addr_nxt;
                r_win_first <= w_first_nxt;
                r_win_last  <= w_last_nxt;
            end
        end
    end

    assign addr_valid = (r_state == ST_RUN);
    assign busy       = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign addr       = r_addr;
    assign win_first  = r_win_first;
    assign win_last   = r_win_last;

endmodule
